// File: rtl/uart_alu_ctrl_pkg.sv
// Shared UART/ALU definitions: FSM state encodings, default byte/opcode
// widths and the default inter-byte timeout. Used by the command
// controller and by the UART receiver/transmitter blocks.
package uart_alu_ctrl_pkg;

  localparam int NB_DATA_DEF       = 8;
  localparam int NB_OP_DEF         = 6;
  localparam int TIMEOUT_TICKS_DEF = 16384;

  // Encodings 6 and 7 are unused and fall back to ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_B   = 3'd1,
    ST_GET_OP  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  // Counter width for a modulo-'ticks' counter. It never drops below 1 bit.
  function automatic int cnt_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/uart_alu_ctrl_tick_timeout.sv
// tick_timeout: inter-byte timeout counter driven by the baud tick.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   clr          synchronous clear; it wins over en, so a byte that arrives
//                on the last tick cancels the expiry
//   en           count enable (one s_tick)
//   expire       combinational; high on the en pulse that completes
//                TIMEOUT_TICKS ticks
// On expiry the counter clears itself, so it never wraps.
module tick_timeout
  import uart_alu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int               CNT_W = cnt_width(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_TICKS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign expire    = en & w_at_last & ~clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr || (en && w_at_last)) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: collects three UART bytes (operand A, operand B, opcode),
// presents them to an external ALU, captures the result and sends it back
// through the UART transmitter.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   s_tick          baud tick, used only as the timeout time base
//   rx_done_tick    one-cycle pulse; rx_data is valid
//   rx_data         received byte
//   alu_result      combinational result from the external ALU
//   tx_done_tick    one-cycle pulse; the transmitter has finished its byte
//   alu_a, alu_b    registered operands
//   alu_op          registered opcode (low NB_OP bits of the third byte)
//   tx_start        one-cycle start pulse for the transmitter (SEND state)
//   tx_data         registered result byte
//   busy            high in every state except IDLE
//   frame_err       one-cycle pulse when the inter-byte timeout aborts a frame
//   overrun         one-cycle pulse when a byte is dropped during EXEC,
//                   SEND or WAIT_TX
module uart_alu_ctrl
  import uart_alu_ctrl_pkg::*;
#(
  parameter int NB_DATA       = NB_DATA_DEF,
  parameter int NB_OP         = NB_OP_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_tick,
  input  logic               rx_done_tick,
  input  logic [NB_DATA-1:0] rx_data,
  input  logic [NB_DATA-1:0] alu_result,
  input  logic               tx_done_tick,
  output logic [NB_DATA-1:0] alu_a,
  output logic [NB_DATA-1:0] alu_b,
  output logic [NB_OP-1:0]   alu_op,
  output logic               tx_start,
  output logic [NB_DATA-1:0] tx_data,
  output logic               busy,
  output logic               frame_err,
  output logic               overrun
);

  state_t             r_state;
  state_t             w_next;
  logic [NB_DATA-1:0] r_alu_a;
  logic [NB_DATA-1:0] r_alu_b;
  logic [NB_OP-1:0]   r_alu_op;
  logic [NB_DATA-1:0] r_tx_data;
  logic               r_frame_err;
  logic               r_overrun;
  logic               w_collecting;
  logic               w_draining;
  logic               w_tmo_clr;
  logic               w_tmo_en;
  logic               w_expire;

  // The timeout runs only while waiting for B or the opcode. Outside those
  // states it is held clear, so every frame starts counting from zero.
  assign w_collecting = (r_state == ST_GET_B) || (r_state == ST_GET_OP);
  assign w_draining   = (r_state == ST_EXEC) || (r_state == ST_SEND) ||
                        (r_state == ST_WAIT_TX);
  assign w_tmo_en     = s_tick & w_collecting;
  assign w_tmo_clr    = ~w_collecting | rx_done_tick;

  tick_timeout #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_tick_timeout (
    .clk   (clk),
    .reset (reset),
    .clr   (w_tmo_clr),
    .en    (w_tmo_en),
    .expire(w_expire)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. w_expire is already masked by rx_done_tick, so a byte
  // that arrives on the final tick always advances the frame.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (rx_done_tick) w_next = ST_GET_B;
      ST_GET_B:   if (rx_done_tick) w_next = ST_GET_OP;
                  else if (w_expire) w_next = ST_IDLE;
      ST_GET_OP:  if (rx_done_tick) w_next = ST_EXEC;
                  else if (w_expire) w_next = ST_IDLE;
      ST_EXEC:    w_next = ST_SEND;
      ST_SEND:    w_next = ST_WAIT_TX;
      ST_WAIT_TX: if (tx_done_tick) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Operand, result and pulse registers. A timeout abort leaves the operands
  // untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_tx_data   <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_expire;
      r_overrun   <= rx_done_tick & w_draining;
      if (rx_done_tick) begin
        case (r_state)
          ST_IDLE:   r_alu_a  <= rx_data;
          ST_GET_B:  r_alu_b  <= rx_data;
          ST_GET_OP: r_alu_op <= rx_data[NB_OP-1:0];
          default:   ;
        endcase
      end
      if (r_state == ST_EXEC) begin
        r_tx_data <= alu_result;
      end
    end
  end

  // Output logic
  always_comb begin
    busy      = (r_state != ST_IDLE);
    tx_start  = (r_state == ST_SEND);
    alu_a     = r_alu_a;
    alu_b     = r_alu_b;
    alu_op    = r_alu_op;
    tx_data   = r_tx_data;
    frame_err = r_frame_err;
    overrun   = r_overrun;
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Testbench for uart_alu_ctrl with a short timeout (4 ticks). It contains
// a fixed vector table of complete frames, hand-written sequences for
// timeout, byte-versus-timeout race, overrun and reset corner cases, and
// random frames checked against a frame-level model.
module tb_uart_alu_ctrl;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic       tx_done_tick = 1'b0;
  logic [7:0] rx_data = '0;
  logic [7:0] alu_result;
  logic [7:0] alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, busy, frame_err, overrun;

  int checks = 0;
  int errors = 0;

  // Pulse counters seen by the output monitor
  int         n_tx = 0;
  int         n_fe = 0;
  int         n_ov = 0;
  logic [7:0] last_tx = '0;

  // External ALU played by the bench
  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_a, alu_b, alu_op);

  uart_alu_ctrl #(
    .NB_DATA(8),
    .NB_OP(6),
    .TIMEOUT_TICKS(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .alu_result  (alu_result),
    .tx_done_tick(tx_done_tick),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_start) begin
      n_tx++;
      last_tx = tx_data;
    end
    if (frame_err) n_fe++;
    if (overrun) n_ov++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic tk);
    rx_data      = b;
    rx_done_tick = 1'b1;
    s_tick       = tk;
    step();
    rx_done_tick = 1'b0;
    s_tick       = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      s_tick = 1'b1;
      step();
      s_tick = 1'b0;
    end
  endtask

  task automatic tx_done();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Random idle cycles with at most max_ticks baud ticks; reports ticks used.
  task automatic gap(input int max_ticks, output int used);
    int n;
    n    = $urandom_range(0, 4);
    used = 0;
    for (int i = 0; i < n; i++) begin
      s_tick = (used < max_ticks) && ($urandom_range(0, 1) == 1);
      if (s_tick) used++;
      step();
    end
    s_tick = 1'b0;
  endtask

  // Deliver n ticks spread out by random idle cycles
  task automatic spread_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) step();
      ticks(1);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [5:0] op;
    logic [7:0] res;
  } vec_t;

  vec_t vt[7];

  initial begin
    int         tx0, fe0, ov0, used, kind, exp_tx, exp_fe, exp_ov;
    logic [7:0] m_a, m_b, a, b, opb, exp_res;
    logic [5:0] m_op;

    vt[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
    vt[1] = '{8'hF0, 8'h20, 8'h20, 6'h20, 8'h10};
    vt[2] = '{8'h10, 8'h11, 8'h22, 6'h22, 8'hFF};
    vt[3] = '{8'hC3, 8'h5A, 8'h24, 6'h24, 8'h42};
    vt[4] = '{8'hC3, 8'h5A, 8'h25, 6'h25, 8'hDB};
    vt[5] = '{8'hFF, 8'h0F, 8'hE5, 6'h25, 8'hFF};
    vt[6] = '{8'h3C, 8'h0F, 8'h3F, 6'h3F, 8'h33};

    // Reset values
    reset = 1'b1;
    step();
    step();
    chk("rst alu_a", alu_a, 0);
    chk("rst alu_b", alu_b, 0);
    chk("rst alu_op", alu_op, 0);
    chk("rst tx_data", tx_data, 0);
    chk("rst busy", busy, 0);
    chk("rst tx_start", tx_start, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst overrun", overrun, 0);
    reset = 1'b0;
    step();

    // Back-to-back complete frames from the vector table
    for (int i = 0; i < 7; i++) begin
      tx0 = n_tx;
      send_byte(vt[i].a, 1'b0);
      chk("tbl busy after A", busy, 1);
      send_byte(vt[i].b, 1'b0);
      send_byte(vt[i].opb, 1'b0);
      chk("tbl tx_start in EXEC", tx_start, 0);
      step();
      chk("tbl tx_start in SEND", tx_start, 1);
      chk("tbl tx_data", tx_data, vt[i].res);
      chk("tbl alu_a", alu_a, vt[i].a);
      chk("tbl alu_b", alu_b, vt[i].b);
      chk("tbl alu_op", alu_op, vt[i].op);
      step();
      chk("tbl tx_start in WAIT_TX", tx_start, 0);
      chk("tbl busy in WAIT_TX", busy, 1);
      step();
      tx_done();
      chk("tbl busy after tx_done", busy, 0);
      chk("tbl tx_start count", n_tx, tx0 + 1);
      chk("tbl captured tx_data", last_tx, vt[i].res);
    end
    chk("tbl no overrun", n_ov, 0);
    chk("tbl no frame_err", n_fe, 0);

    // Timeout in GET_B, then restart with a new operand A
    do_reset();
    fe0 = n_fe;
    send_byte(8'h11, 1'b0);
    ticks(TMO - 1);
    chk("tmo frame_err early", frame_err, 0);
    chk("tmo busy early", busy, 1);
    ticks(1);
    chk("tmo frame_err pulse", frame_err, 1);
    chk("tmo busy after abort", busy, 0);
    chk("tmo alu_a kept", alu_a, 8'h11);
    step();
    chk("tmo frame_err one cycle", frame_err, 0);
    send_byte(8'h22, 1'b0);
    chk("tmo next byte is A", alu_a, 8'h22);
    chk("tmo busy again", busy, 1);
    // Timeout in GET_OP keeps operand B
    send_byte(8'h33, 1'b0);
    ticks(TMO);
    chk("tmo GET_OP busy", busy, 0);
    chk("tmo GET_OP alu_b kept", alu_b, 8'h33);
    step();
    chk("tmo frame_err count", n_fe, fe0 + 2);

    // Opcode byte on the same cycle as the expiring tick
    do_reset();
    fe0 = n_fe;
    send_byte(8'h07, 1'b0);
    ticks(TMO - 1);
    send_byte(8'h09, 1'b0);
    ticks(TMO - 1);
    send_byte(8'h20, 1'b1);
    chk("race frame_err", frame_err, 0);
    chk("race busy", busy, 1);
    chk("race tx_start in EXEC", tx_start, 0);
    step();
    chk("race tx_start", tx_start, 1);
    chk("race tx_data", tx_data, 8'h10);
    step();
    tx_done();
    chk("race busy end", busy, 0);
    chk("race no frame_err", n_fe, fe0);

    // Byte dropped in WAIT_TX; no timeout in WAIT_TX
    do_reset();
    send_byte(8'h05, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h20, 1'b0);
    step();
    step();
    ov0 = n_ov;
    send_byte(8'hAA, 1'b0);
    chk("ovr pulse", overrun, 1);
    chk("ovr alu_a kept", alu_a, 8'h05);
    chk("ovr alu_b kept", alu_b, 8'h03);
    chk("ovr busy", busy, 1);
    step();
    chk("ovr one cycle", overrun, 0);
    ticks(3 * TMO);
    chk("ovr WAIT_TX no timeout", busy, 1);
    tx_done();
    chk("ovr idle after tx_done", busy, 0);
    chk("ovr count", n_ov, ov0 + 1);
    send_byte(8'h44, 1'b0);
    chk("ovr next byte is A", alu_a, 8'h44);

    // Reset asserted in GET_OP (tx_data still holds 0x08)
    send_byte(8'h34, 1'b0);
    tx0 = n_tx;
    fe0 = n_fe;
    #2;
    reset = 1'b1;
    #1;
    chk("arst alu_a", alu_a, 0);
    chk("arst alu_b", alu_b, 0);
    chk("arst alu_op", alu_op, 0);
    chk("arst tx_data", tx_data, 0);
    chk("arst busy", busy, 0);
    chk("arst tx_start", tx_start, 0);
    chk("arst frame_err", frame_err, 0);
    chk("arst overrun", overrun, 0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("arst no tx_start", n_tx, tx0);
    chk("arst no frame_err", n_fe, fe0);
    send_byte(8'h5A, 1'b0);
    chk("arst first byte is A", alu_a, 8'h5A);
    chk("arst alu_b still 0", alu_b, 0);

    // Random frames against a frame-level model
    do_reset();
    m_a = '0;
    m_b = '0;
    m_op = '0;
    exp_tx = n_tx;
    exp_fe = n_fe;
    exp_ov = n_ov;
    exp_res = '0;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      a    = 8'($urandom);
      b    = 8'($urandom);
      opb  = 8'($urandom);
      if ($urandom_range(0, 1) == 1) opb[5:0] = 6'h20 | 6'($urandom_range(0, 5));
      send_byte(a, 1'($urandom_range(0, 1)));
      m_a = a;
      gap(TMO - 1, used);
      if (kind >= 7 && kind <= 8) begin
        spread_ticks(TMO - used);
        exp_fe++;
      end else begin
        send_byte(b, 1'($urandom_range(0, 1)));
        m_b = b;
        gap(TMO - 1, used);
        if (kind == 9) begin
          spread_ticks(TMO - used);
          exp_fe++;
        end else begin
          send_byte(opb, 1'($urandom_range(0, 1)));
          m_op = opb[5:0];
          exp_tx++;
          exp_res = ref_alu(m_a, m_b, m_op);
          if ($urandom_range(0, 3) == 0) begin
            rx_data      = 8'($urandom);
            rx_done_tick = 1'b1;
            exp_ov++;
          end
          step();
          rx_done_tick = 1'b0;
          step();
          repeat ($urandom_range(0, 5)) begin
            s_tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
              rx_data      = 8'($urandom);
              rx_done_tick = 1'b1;
              exp_ov++;
            end
            step();
            rx_done_tick = 1'b0;
            s_tick       = 1'b0;
          end
          tx_done();
        end
      end
      step();
      chk("rnd busy idle", busy, 0);
      chk("rnd alu_a", alu_a, m_a);
      chk("rnd alu_b", alu_b, m_b);
      chk("rnd alu_op", alu_op, m_op);
      chk("rnd tx_start count", n_tx, exp_tx);
      chk("rnd frame_err count", n_fe, exp_fe);
      chk("rnd overrun count", n_ov, exp_ov);
      if (kind < 7) chk("rnd tx_data", last_tx, exp_res);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
